// File: rtl/fir_pipe_pkg.sv
// fir_pipe_pkg: width helpers shared by the parametrised pipelined FIR and its coefficient bank.
package fir_pipe_pkg;

    function automatic int prod_w(input int sample_w, input int coef_w);
        return sample_w + coef_w;
    endfunction

    // One growth bit per doubling of the tap count keeps the adder chain overflow-free.
    function automatic int acc_w(input int sample_w, input int coef_w, input int order);
        return prod_w(sample_w, coef_w) + $clog2(order + 1);
    endfunction

    function automatic int addr_w(input int order);
        return order > 0 ? $clog2(order + 1) : 1;
    endfunction

    // Fill count must hold the value ORDER+1.
    function automatic int cnt_w(input int order);
        return $clog2(order + 2);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: double-buffered coefficients; writes land in the shadow bank, commit copies it to the active bank.
module fir_coef_bank
    import fir_pipe_pkg::*;
#(
    parameter int ORDER  = 6,
    parameter int COEF_W = 5,
    parameter int AW     = addr_w(ORDER)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [AW-1:0]               i_wr_addr,
    input  logic [COEF_W-1:0]           i_wr_data,
    input  logic                        i_commit,
    output logic [(ORDER+1)*COEF_W-1:0] o_active
);

    logic [COEF_W-1:0] r_shadow [ORDER+1];
    logic [COEF_W-1:0] r_active [ORDER+1];

    // Commit samples the shadow bank before a same-edge write lands.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_shadow <= '{default: '0};
            r_active <= '{default: '0};
        end else begin
            if (i_commit) r_active <= r_shadow;
            if (i_wr_en && i_wr_addr <= AW'(ORDER)) r_shadow[i_wr_addr] <= i_wr_data;
        end

    for (genvar k = 0; k <= ORDER; k++) begin : g_flat
        assign o_active[k*COEF_W +: COEF_W] = r_active[k];
    end

endmodule

// File: rtl/fir_pipe_param.sv
// fir_pipe_param: streaming transposed-form FIR with bubbles, double-buffered coefficients, flush and primed flag.
// Define FIR_SAT_EN to clamp the output to OUT_W bits (and raise o_fir_sat); otherwise the output wraps.
module fir_pipe_param
    import fir_pipe_pkg::*;
#(
    parameter int   ORDER    = 6,
    parameter int   SAMPLE_W = 4,
    parameter int   COEF_W   = 5,
    parameter int   OUT_W    = SAMPLE_W + COEF_W + $clog2(ORDER + 1),
    localparam int  AW       = addr_w(ORDER)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic [SAMPLE_W-1:0] i_sample_in,
    input  logic                i_sample_valid,
    input  logic                i_coef_wr_en,
    input  logic [AW-1:0]       i_coef_wr_addr,
    input  logic [COEF_W-1:0]   i_coef_wr_data,
    input  logic                i_coef_commit,
    output logic [OUT_W-1:0]    o_fir_out,
    output logic                o_fir_valid,
    output logic                o_fir_primed,
    output logic                o_fir_sat
);

    localparam int ACC_W = acc_w(SAMPLE_W, COEF_W, ORDER);
    localparam int CW    = cnt_w(ORDER);
    localparam int N     = ORDER + 1;

    logic [N*COEF_W-1:0] w_h;
    logic [SAMPLE_W-1:0] r_x_d;
    logic                r_v1;
    logic                r_v2;
    logic [ACC_W-1:0]    r_s      [N];
    logic [ACC_W-1:0]    w_s_next [N];
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [OUT_W-1:0]    w_out;
    logic                w_sat;

    fir_coef_bank #(.ORDER(ORDER), .COEF_W(COEF_W), .AW(AW)) u_bank (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_coef_wr_en),
        .i_wr_addr (i_coef_wr_addr),
        .i_wr_data (i_coef_wr_data),
        .i_commit  (i_coef_commit),
        .o_active  (w_h)
    );

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_x_d <= '0;
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
        end else if (i_flush) begin
            r_x_d <= '0;
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
        end else begin
            if (i_sample_valid) r_x_d <= i_sample_in;
            r_v1 <= i_sample_valid;
            r_v2 <= r_v1;
        end

    for (genvar k = 0; k < N; k++) begin : g_tap
        logic [ACC_W-1:0] w_prod;
        assign w_prod = ACC_W'(r_x_d) * ACC_W'(w_h[k*COEF_W +: COEF_W]);
        if (k < ORDER) begin : g_mid
            assign w_s_next[k] = w_prod + r_s[k+1];
        end else begin : g_last
            assign w_s_next[k] = w_prod;
        end
    end

    // The chain only advances on real samples, so bubbles leave the history untouched.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_s <= '{default: '0};
        else if (i_flush) r_s <= '{default: '0};
        else if (r_v1) r_s <= w_s_next;

`ifdef FIR_SAT_EN
    assign w_sat = (OUT_W < ACC_W) && |(r_s[0] >> OUT_W);
    assign w_out = w_sat ? '1 : OUT_W'(r_s[0]);
`else
    assign w_sat = 1'b0;
    assign w_out = OUT_W'(r_s[0]);
`endif

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            o_fir_out   <= '0;
            o_fir_valid <= 1'b0;
            o_fir_sat   <= 1'b0;
        end else if (i_flush) begin
            o_fir_out   <= '0;
            o_fir_valid <= 1'b0;
            o_fir_sat   <= 1'b0;
        end else begin
            o_fir_out   <= w_out;
            o_fir_valid <= r_v2;
            o_fir_sat   <= w_sat;
        end

    assign w_cnt_next = (i_sample_valid && r_cnt != CW'(N)) ? r_cnt + CW'(1) : r_cnt;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_cnt        <= '0;
            o_fir_primed <= 1'b0;
        end else if (i_flush) begin
            r_cnt        <= '0;
            o_fir_primed <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            o_fir_primed <= w_cnt_next == CW'(N);
        end

endmodule

// File: tb/tb_fir_pipe_param.sv
// tb_fir_pipe_param: scoreboard bench driving a full-width and an 8-bit-output fir_pipe_param side by side.
module tb_fir_pipe_param;

    localparam int ORDER = 6, N = 7, SW = 4, CW = 5, AW = 3, OW = 12;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, sv = 1'b0, we = 1'b0, commit = 1'b0;
    logic [SW-1:0] x  = '0;
    logic [AW-1:0] wa = '0;
    logic [CW-1:0] wd = '0;
    logic [OW-1:0] out;
    logic          valid, primed, sat;
    logic [7:0]    out8;
    logic          valid8, primed8, sat8;

    int pass_cnt = 0, total = 0;
    int shadow [N], active [N], hist [N];
    int expq [$];
    int cnt = 0;
    logic [2:0] vpipe = '0;

    always #5 clk = ~clk;

    fir_pipe_param u_dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_sample_in(x), .i_sample_valid(sv),
        .i_coef_wr_en(we), .i_coef_wr_addr(wa), .i_coef_wr_data(wd), .i_coef_commit(commit),
        .o_fir_out(out), .o_fir_valid(valid), .o_fir_primed(primed), .o_fir_sat(sat)
    );

    fir_pipe_param #(.OUT_W(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_sample_in(x), .i_sample_valid(sv),
        .i_coef_wr_en(we), .i_coef_wr_addr(wa), .i_coef_wr_data(wd), .i_coef_commit(commit),
        .o_fir_out(out8), .o_fir_valid(valid8), .o_fir_primed(primed8), .o_fir_sat(sat8)
    );

    function automatic logic [8:0] exp8(input int y);
`ifdef FIR_SAT_EN
        return y > 255 ? 9'h1FF : {1'b0, 8'(y)};
`else
        return {1'b0, 8'(y)};
`endif
    endfunction

    task automatic clear_model(input bit all);
        for (int k = 0; k < N; k++) begin
            hist[k] = 0;
            if (all) begin
                shadow[k] = 0;
                active[k] = 0;
            end
        end
        expq.delete();
        vpipe = '0;
        cnt = 0;
    endtask

    task automatic drive(input bit v, input int s, input bit fl = 0, input bit w = 0,
                         input int a = 0, input int d = 0, input bit c = 0);
        int y;
        sv = v; x = SW'(s); flush = fl; we = w; wa = AW'(a); wd = CW'(d); commit = c;
        @(posedge clk);
        if (c) active = shadow;
        if (w && a <= ORDER) shadow[a] = d;
        if (fl) clear_model(0);
        else begin
            vpipe = {vpipe[1:0], v};
            if (v) begin
                for (int k = ORDER; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = s;
                y = 0;
                for (int k = 0; k < N; k++) y += active[k] * hist[k];
                expq.push_back(y);
                if (cnt < N) cnt++;
            end
        end
        @(negedge clk);
        sv = 0; flush = 0; we = 0; commit = 0;
    endtask

    task automatic load_coefs(input int h [N], input bit c);
        for (int k = 0; k < N; k++) drive(0, 0, 0, 1, k, h[k]);
        if (c) drive(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out !== '0 || valid !== 1'b0 || primed !== 1'b0 || sat !== 1'b0)
            $display("FAIL reset wide: out=%0d valid=%b primed=%b sat=%b, want all 0", out, valid, primed, sat);
        else pass_cnt++;
        total++;
        if (out8 !== '0 || valid8 !== 1'b0 || primed8 !== 1'b0 || sat8 !== 1'b0)
            $display("FAIL reset narrow: out=%0d valid=%b primed=%b sat=%b, want all 0", out8, valid8, primed8, sat8);
        else pass_cnt++;
        rst = 1'b0;
        clear_model(1);
    endtask

    task automatic test_impulse(input string nm, input int maxgap);
        int vs [$], ss [$];
        int y, nout;
        logic [8:0] e8;
        nout = 0;
        drive(0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            vs.push_back(1);
            ss.push_back(i == 0 ? 1 : 0);
            repeat ($urandom_range(0, maxgap)) begin
                vs.push_back(0);
                ss.push_back(0);
            end
        end
        repeat (3) begin vs.push_back(0); ss.push_back(0); end
        foreach (vs[i]) begin
            drive(vs[i][0], ss[i]);
            total++;
            if (valid !== vpipe[2] || valid8 !== vpipe[2])
                $display("FAIL %s valid: got %b/%b want %b", nm, valid, valid8, vpipe[2]);
            else pass_cnt++;
            if (valid === 1'b1 && expq.size() > 0) begin
                y = expq.pop_front();
                e8 = exp8(y);
                nout++;
                total++;
                if (out !== OW'(y) || sat !== 1'b0)
                    $display("FAIL %s out: got %0d sat %b want %0d sat 0", nm, out, sat, y);
                else pass_cnt++;
                total++;
                if ({sat8, out8} !== e8)
                    $display("FAIL %s out8: got %0d sat %b want %0d sat %b", nm, out8, sat8, e8[7:0], e8[8]);
                else pass_cnt++;
            end
        end
        total++;
        if (nout !== 8 || expq.size() !== 0)
            $display("FAIL %s count: got %0d outputs, %0d pending, want 8 and 0", nm, nout, expq.size());
        else pass_cnt++;
    endtask

    task automatic test_step;
        int vs [$];
        int y;
        logic [8:0] e8;
        drive(0, 0, 1);
        vs = '{10, 10, 10, 10, 10, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            drive(i < 9, i < 9 ? vs[i] : 0);
            total++;
            if (primed !== (cnt == N) || primed8 !== (cnt == N))
                $display("FAIL step primed: got %b/%b want %b after %0d samples", primed, primed8, cnt == N, cnt);
            else pass_cnt++;
            total++;
            if (valid !== vpipe[2])
                $display("FAIL step valid: got %b want %b", valid, vpipe[2]);
            else pass_cnt++;
            if (valid === 1'b1 && expq.size() > 0) begin
                y = expq.pop_front();
                e8 = exp8(y);
                total++;
                if (out !== OW'(y) || {sat8, out8} !== e8)
                    $display("FAIL step out: got %0d/%0d want %0d/%0d", out, out8, y, e8[7:0]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_flush;
        int y;
        drive(0, 0, 1);
        repeat (3) drive(1, 10);
        drive(1, 10, 1);
        total++;
        if (out !== '0 || valid !== 1'b0 || primed !== 1'b0 || out8 !== '0 || valid8 !== 1'b0)
            $display("FAIL flush clear: out=%0d valid=%b primed=%b out8=%0d, want 0", out, valid, primed, out8);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, i == 0 ? 3 : 0);
            total++;
            if (valid !== vpipe[2])
                $display("FAIL flush valid: got %b want %b", valid, vpipe[2]);
            else pass_cnt++;
            if (valid === 1'b1 && expq.size() > 0) begin
                y = expq.pop_front();
                total++;
                if (out !== OW'(y))
                    $display("FAIL flush out: got %0d want %0d", out, y);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_coef_shadow;
        load_coefs('{2, 2, 2, 2, 2, 2, 2}, 0);
        test_impulse("shadow_uncommitted", 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        test_impulse("committed", 0);
        drive(0, 0, 0, 1, 0, 9, 1);
        drive(0, 0, 0, 1, 7, 31);
        test_impulse("wr_commit_same_edge", 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        test_impulse("late_commit", 0);
    endtask

    task automatic test_sat;
        int y;
        logic [8:0] e8;
        load_coefs('{31, 31, 31, 31, 31, 31, 31}, 1);
        drive(0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            drive(i < 9, 15);
            if (valid === 1'b1 && expq.size() > 0) begin
                y = expq.pop_front();
                e8 = exp8(y);
                total++;
                if (out !== OW'(y) || sat !== 1'b0)
                    $display("FAIL sat wide: got %0d sat %b want %0d sat 0", out, sat, y);
                else pass_cnt++;
                total++;
                if ({sat8, out8} !== e8)
                    $display("FAIL sat narrow: got %0d sat %b want %0d sat %b", out8, sat8, e8[7:0], e8[8]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(0, 0, 1);
        repeat (3) drive(1, 5);
        rst = 1'b1;
        #1;
        total++;
        if (out !== '0 || valid !== 1'b0 || primed !== 1'b0 || out8 !== '0 || sat8 !== 1'b0)
            $display("FAIL reset_mid: out=%0d valid=%b primed=%b out8=%0d sat8=%b, want 0", out, valid, primed, out8, sat8);
        else pass_cnt++;
        clear_model(1);
        @(negedge clk);
        rst = 1'b0;
        test_impulse("after_reset_zero_coefs", 0);
    endtask

    initial begin
        test_reset();
        load_coefs('{1, 2, 3, 4, 5, 6, 7}, 1);
        test_impulse("impulse", 0);
        test_step();
        test_impulse("impulse_bubbles", 3);
        test_flush();
        test_coef_shadow();
        test_sat();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
